// File: rtl/condicionador_botoes_pkg.sv
// Shared definitions for the button conditioner and the game datapath:
// FSM state codes, default timing parameters and the one-hot test.
package jogo_pkg;

  typedef logic [2:0] estado_t;

  localparam logic [2:0] ESPERA = 3'd0;
  localparam logic [2:0] FILTRA = 3'd1;
  localparam logic [2:0] EMITE  = 3'd2;
  localparam logic [2:0] SEGURA = 3'd3;
  localparam logic [2:0] SOLTA  = 3'd4;

  localparam int DEBOUNCE_DEF = 3;
  localparam int TIMEOUT_DEF  = 5000;

  function automatic logic eh_one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/condicionador_botoes_if.sv
// Signal bundle between the button conditioner and the game FSM.
// The game side is the master; the conditioner is the slave.
interface condicionador_botoes_if;
  import jogo_pkg::*;

  logic [3:0] botoes;
  logic       habilita;
  logic       conta_timeout;
  logic [3:0] jogada;
  logic       tem_jogada;
  logic       jogada_invalida;
  logic       timeout;
  estado_t    db_estado;

  modport master (
    output botoes, habilita, conta_timeout,
    input  jogada, tem_jogada, jogada_invalida, timeout, db_estado
  );

  modport slave (
    input  botoes, habilita, conta_timeout,
    output jogada, tem_jogada, jogada_invalida, timeout, db_estado
  );
endinterface

// File: rtl/condicionador_botoes_contador.sv
// Saturating mod-M counter with synchronous clear and a registered
// terminal-count flag that tracks the value being loaded.
module contador_m #(
  parameter int M = 5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);
  localparam int W = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0] MAX = W'(M - 1);

  logic [W-1:0] valor_q, valor_d;
  logic         tc_q;

  always_comb begin
    valor_d = valor_q;
    if (clear_i)
      valor_d = '0;
    else if (enable_i && (valor_q != MAX))
      valor_d = valor_q + W'(1);
  end

  // tc follows the next value so it asserts on the same edge the count lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valor_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      valor_q <= valor_d;
      tc_q    <= (valor_d == MAX);
    end
  end

  assign tc_o = tc_q;
endmodule

// File: rtl/condicionador_botoes.sv
// Synchronizes and debounces the four player buttons, emitting one play
// (or one error) per physical press, plus the inactivity timeout.
module condicionador_botoes
  import jogo_pkg::*;
#(
  parameter int DEBOUNCE       = DEBOUNCE_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  condicionador_botoes_if.slave  io
);
  localparam int CW = $clog2(DEBOUNCE);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic [3:0]    b_meta_q, b_s_q;
  estado_t       state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    jogada_q, jogada_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic          limpa_timeout;
  logic          timeout_s;

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    jogada_d = jogada_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ESPERA: begin
        if (b_s_q != 4'b0000) begin
          cand_d  = b_s_q;
          cnt_d   = '0;
          state_d = FILTRA;
        end
      end
      FILTRA: begin
        if (b_s_q == cand_q) begin
          if (cnt_q == CNT_MAX) begin
            state_d = EMITE;
            if (!eh_one_hot(cand_q)) begin
              err_d = 1'b1;
            end else if (io.habilita) begin
              jogada_d = cand_q;
              ok_d     = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (b_s_q == 4'b0000) begin
          state_d = ESPERA;
        end else begin
          cand_d = b_s_q;
          cnt_d  = '0;
        end
      end
      EMITE: state_d = SEGURA;
      SEGURA: begin
        if (b_s_q == 4'b0000) begin
          cnt_d   = '0;
          state_d = SOLTA;
        end
      end
      SOLTA: begin
        // a bounce during release restarts the hold wait instead of emitting
        if (b_s_q != 4'b0000)
          state_d = SEGURA;
        else if (cnt_q == CNT_MAX)
          state_d = ESPERA;
        else
          cnt_d = cnt_q + CW'(1);
      end
      default: state_d = ESPERA;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      b_meta_q <= '0;
      b_s_q    <= '0;
      state_q  <= ESPERA;
      cand_q   <= '0;
      cnt_q    <= '0;
      jogada_q <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      b_meta_q <= io.botoes;
      b_s_q    <= b_meta_q;
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      jogada_q <= jogada_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
    end
  end

  // an accepted play restarts the inactivity window on the edge it is loaded
  assign limpa_timeout = !io.conta_timeout || ok_d;

  contador_m #(.M(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clock),
    .rst_n    (reset),
    .clear_i  (limpa_timeout),
    .enable_i (io.conta_timeout),
    .tc_o     (timeout_s)
  );

  assign io.jogada          = jogada_q;
  assign io.tem_jogada      = ok_q;
  assign io.jogada_invalida = err_q;
  assign io.timeout         = timeout_s;
  assign io.db_estado       = state_q;
endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes: a press table plus hand-built release,
// reset and timeout sequences; expected pulses go through a timed scoreboard.
module tb_condicionador_botoes;
  localparam int DEB = 3;
  localparam int TMO = 20;
  localparam int LAT = DEB + 3; // drive-after-edge c -> pulse seen after edge c+LAT

  logic clock = 1'b0;
  logic reset = 1'b0;
  condicionador_botoes_if bus ();

  condicionador_botoes #(.DEBOUNCE(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus.slave)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ok    = 0;
  int n_err   = 0;

  typedef struct {
    bit          inval;
    int unsigned cyc;
    logic [3:0]  jog;
  } ev_t;
  ev_t exp_q[$];

  typedef struct {
    logic [3:0] b;
    logic       hab;
    int         hold;
    int         exp_ok;
    int         exp_err;
    logic [3:0] exp_jog;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input bit inval, input int unsigned c, input logic [3:0] jog);
    ev_t e;
    e.inval = inval;
    e.cyc   = c;
    e.jog   = jog;
    exp_q.push_back(e);
  endtask

  // scoreboard: every pulse must match the oldest pending expectation
  always @(negedge clock) begin
    ev_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check("missed_pulse", cyc, exp_q[0].cyc);
      e = exp_q.pop_front();
    end
    if (bus.tem_jogada || bus.jogada_invalida) begin
      if (bus.tem_jogada) n_ok++;
      if (bus.jogada_invalida) n_err++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {bus.tem_jogada, bus.jogada_invalida}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_kind", {bus.tem_jogada, bus.jogada_invalida}, e.inval ? 2'b01 : 2'b10);
        if (!e.inval) check("pulse_jogada", bus.jogada, e.jog);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c;
    logic [3:0] exp_jog;

    vecs[0] = '{4'b0001, 1'b1, 5,  1, 0, 4'b0001};
    vecs[1] = '{4'b0100, 1'b1, 3,  0, 0, 4'b0001};
    vecs[2] = '{4'b0110, 1'b1, 5,  0, 1, 4'b0001};
    vecs[3] = '{4'b0010, 1'b0, 6,  0, 0, 4'b0001};
    vecs[4] = '{4'b1000, 1'b1, 4,  1, 0, 4'b1000};
    vecs[5] = '{4'b1111, 1'b0, 5,  0, 1, 4'b1000};
    vecs[6] = '{4'b0100, 1'b1, 12, 1, 0, 4'b0100};
    vecs[7] = '{4'b0010, 1'b1, 1,  0, 0, 4'b0100};

    bus.botoes        = 4'b0000;
    bus.habilita      = 1'b0;
    bus.conta_timeout = 1'b0;

    tick(3);
    check("rst_jogada", bus.jogada, 4'b0000);
    check("rst_tem", bus.tem_jogada, 1'b0);
    check("rst_inv", bus.jogada_invalida, 1'b0);
    check("rst_timeout", bus.timeout, 1'b0);
    check("rst_estado", bus.db_estado, 3'd0);
    reset = 1'b1;
    tick(4);

    for (int i = 0; i < 8; i++) begin
      n_ok = 0;
      n_err = 0;
      bus.habilita = vecs[i].hab;
      tick(1);
      c = cyc;
      bus.botoes = vecs[i].b;
      if (vecs[i].exp_ok > 0) push(1'b0, c + LAT, vecs[i].b);
      if (vecs[i].exp_err > 0) push(1'b1, c + LAT, 4'b0000);
      tick(vecs[i].hold);
      bus.botoes = 4'b0000;
      tick(12);
      check($sformatf("v%0d_n_ok", i), n_ok, vecs[i].exp_ok);
      check($sformatf("v%0d_n_err", i), n_err, vecs[i].exp_err);
      check($sformatf("v%0d_jogada", i), bus.jogada, vecs[i].exp_jog);
      check($sformatf("v%0d_estado", i), bus.db_estado, 3'd0);
    end
    exp_jog = 4'b0100;

    // release with one-cycle glitches: only the original press may emit
    n_ok = 0;
    n_err = 0;
    bus.habilita = 1'b1;
    tick(1);
    c = cyc;
    bus.botoes = 4'b0010;
    push(1'b0, c + LAT, 4'b0010);
    exp_jog = 4'b0010;
    tick(6);
    bus.botoes = 4'b0000;
    tick(2);
    bus.botoes = 4'b0010;
    tick(1);
    bus.botoes = 4'b0000;
    tick(2);
    bus.botoes = 4'b0010;
    tick(1);
    bus.botoes = 4'b0000;
    tick(12);
    check("glitch_n_ok", n_ok, 1);
    check("glitch_n_err", n_err, 0);
    check("glitch_jogada", bus.jogada, exp_jog);
    check("glitch_estado", bus.db_estado, 3'd0);

    // asynchronous reset in the middle of FILTRA, button still held afterwards
    n_ok = 0;
    tick(1);
    bus.botoes = 4'b0001;
    tick(3);
    check("pre_rst_filtra", bus.db_estado, 3'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_jogada", bus.jogada, 4'b0000);
    check("mid_rst_tem", bus.tem_jogada, 1'b0);
    check("mid_rst_inv", bus.jogada_invalida, 1'b0);
    check("mid_rst_timeout", bus.timeout, 1'b0);
    check("mid_rst_estado", bus.db_estado, 3'd0);
    tick(2);
    reset = 1'b1;
    c = cyc;
    push(1'b0, c + LAT, 4'b0001);
    exp_jog = 4'b0001;
    tick(8);
    bus.botoes = 4'b0000;
    tick(12);
    check("post_rst_n_ok", n_ok, 1);
    check("post_rst_jogada", bus.jogada, exp_jog);

    // inactivity timeout with no presses
    tick(1);
    c = cyc;
    bus.conta_timeout = 1'b1;
    tick(TMO - 2);
    check("tmo_before", bus.timeout, 1'b0);
    tick(1);
    check("tmo_reached", bus.timeout, 1'b1);
    tick(11);
    check("tmo_held", bus.timeout, 1'b1);
    bus.conta_timeout = 1'b0;
    tick(1);
    check("tmo_cleared", bus.timeout, 1'b0);

    // play accepted at cycle 15 restarts the window
    tick(1);
    c = cyc;
    bus.conta_timeout = 1'b1;
    tick(15 - LAT);
    bus.botoes = 4'b1000;
    push(1'b0, c + 15, 4'b1000);
    exp_jog = 4'b1000;
    tick(6);
    bus.botoes = 4'b0000;
    tick(5);
    check("restart_not_at_19", bus.timeout, 1'b0);
    tick(13);
    check("restart_before", bus.timeout, 1'b0);
    tick(1);
    check("restart_reached", bus.timeout, 1'b1);
    bus.conta_timeout = 1'b0;
    tick(12);

    // play accepted on exactly the edge the counter would reach terminal count
    tick(1);
    c = cyc;
    bus.conta_timeout = 1'b1;
    tick(TMO - 1 - LAT);
    bus.botoes = 4'b0100;
    push(1'b0, c + TMO - 1, 4'b0100);
    exp_jog = 4'b0100;
    tick(6);
    bus.botoes = 4'b0000;
    check("simul_tmo_low", bus.timeout, 1'b0);
    tick(1);
    check("simul_tmo_after", bus.timeout, 1'b0);
    tick(TMO - 3);
    check("simul_before", bus.timeout, 1'b0);
    tick(1);
    check("simul_reached", bus.timeout, 1'b1);
    check("final_jogada", bus.jogada, exp_jog);
    bus.conta_timeout = 1'b0;
    tick(5);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
